// File: rtl/chess_clock_pkg.sv
// Shared constants and helpers for the chess clock countdown stages.
// Covers the BCD digit type, the digit limits, the default tick divider and the INC bit indices.
package chess_clock_pkg;

   localparam int BCD_W = 4;

   typedef logic [BCD_W-1:0] bcd_t;

   localparam bcd_t BCD_MAX_DEC = 4'd9;
   localparam bcd_t BCD_MAX_SEX = 4'd5;

   localparam int TICK_DIV_DEF = 50_000_000;

   localparam int IDX_S0 = 0;
   localparam int IDX_S1 = 1;
   localparam int IDX_M0 = 2;
   localparam int IDX_M1 = 3;

   // Increment modulo (max+1), without producing a carry.
   function automatic bcd_t bcd_inc(input bcd_t d, input bcd_t max);
      return (d == max) ? '0 : d + 1'b1;
   endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD digit of the countdown: decrement with borrow, increment without carry.
// Ports: CLK, CLR (sync reset to RST), CE, dec/borrow_in, inc; outputs borrow_out and q.
module bcd_digit_cell
   import chess_clock_pkg::*;
#(
   parameter bcd_t MAX = BCD_MAX_DEC,
   parameter bcd_t RST = '0
) (
   input  logic CLK,
   input  logic CLR,
   input  logic CE,
   input  logic dec,
   input  logic borrow_in,
   input  logic inc,
   output logic borrow_out,
   output bcd_t q
);

   if (RST > MAX) begin : g_bad_rst
      $error("bcd_digit_cell: reset value exceeds digit range");
   end

   // This digit rolls over only when every lower digit is also zero.
   assign borrow_out = borrow_in & (q == '0);

   always_ff @(posedge CLK) begin
      if (CLR) begin
         q <= RST;
      end else if (CE) begin
         if (dec && borrow_in) begin
            q <= (q == '0) ? MAX : q - 1'b1;
         end else if (inc) begin
            q <= bcd_inc(q, MAX);
         end
      end
   end

endmodule

// File: rtl/player_time_counter.sv
// Per-player mm:ss BCD countdown with set-mode digit editing and sticky timeout flag.
// In: CLK, CLR, CE, RUN, SET_MODE, SET_PULSE, INC[3:0]; out: M1, M0, S1, S0, TIMEOUT.
module player_time_counter
   import chess_clock_pkg::*;
#(
   parameter int   TICK_DIV = TICK_DIV_DEF,
   parameter bcd_t INIT_M1  = 4'd0,
   parameter bcd_t INIT_M0  = 4'd5
) (
   input  logic       CLK,
   input  logic       CLR,
   input  logic       CE,
   input  logic       RUN,
   input  logic       SET_MODE,
   input  logic       SET_PULSE,
   input  logic [3:0] INC,
   output bcd_t       M1,
   output bcd_t       M0,
   output bcd_t       S1,
   output bcd_t       S0,
   output logic       TIMEOUT
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   if (TICK_DIV < 1) begin : g_bad_div
      $error("player_time_counter: TICK_DIV must be at least 1");
   end

   logic [PW-1:0] presc;
   logic          pulse_q;
   logic          count;
   logic          wrap;
   logic          zero;
   logic          tick;
   logic          edit;
   logic          last_sec;
   logic          edit_nz;
   logic [3:0]    inc_en;
   logic          b_s0;
   logic          b_s1;
   logic          b_m0;
   logic          b_m1;

   assign count = CE & RUN & ~SET_MODE & ~TIMEOUT;
   assign wrap  = count & (presc == PW'(TICK_DIV - 1));
   assign zero  = ~|{M1, M0, S1, S0};
   // 00:00 saturates even when reached by editing with TIMEOUT clear.
   assign tick  = wrap & ~zero;
   assign edit  = CE & SET_MODE & SET_PULSE & ~pulse_q;

   assign inc_en   = {4{edit}} & INC;
   assign last_sec = ({M1, M0, S1, S0} == 16'h0001);

   assign edit_nz = |{
      INC[IDX_M1] ? bcd_inc(M1, BCD_MAX_DEC) : M1,
      INC[IDX_M0] ? bcd_inc(M0, BCD_MAX_DEC) : M0,
      INC[IDX_S1] ? bcd_inc(S1, BCD_MAX_SEX) : S1,
      INC[IDX_S0] ? bcd_inc(S0, BCD_MAX_DEC) : S0
   };

   always_ff @(posedge CLK) begin
      if (CLR) begin
         presc   <= '0;
         pulse_q <= 1'b0;
         TIMEOUT <= 1'b0;
      end else if (CE) begin
         pulse_q <= SET_PULSE;
         // Held (not cleared) when count drops so partial seconds survive turns.
         if (SET_MODE) begin
            presc <= '0;
         end else if (count) begin
            presc <= wrap ? '0 : presc + 1'b1;
         end
         if (tick && last_sec) begin
            TIMEOUT <= 1'b1;
         end else if (edit && edit_nz) begin
            TIMEOUT <= 1'b0;
         end
      end
   end

   bcd_digit_cell #(.MAX(BCD_MAX_DEC), .RST(4'd0)) u_s0 (
      .CLK(CLK), .CLR(CLR), .CE(CE),
      .dec(tick), .borrow_in(1'b1), .inc(inc_en[IDX_S0]),
      .borrow_out(b_s0), .q(S0)
   );

   bcd_digit_cell #(.MAX(BCD_MAX_SEX), .RST(4'd0)) u_s1 (
      .CLK(CLK), .CLR(CLR), .CE(CE),
      .dec(tick), .borrow_in(b_s0), .inc(inc_en[IDX_S1]),
      .borrow_out(b_s1), .q(S1)
   );

   bcd_digit_cell #(.MAX(BCD_MAX_DEC), .RST(INIT_M0)) u_m0 (
      .CLK(CLK), .CLR(CLR), .CE(CE),
      .dec(tick), .borrow_in(b_s1), .inc(inc_en[IDX_M0]),
      .borrow_out(b_m0), .q(M0)
   );

   bcd_digit_cell #(.MAX(BCD_MAX_DEC), .RST(INIT_M1)) u_m1 (
      .CLK(CLK), .CLR(CLR), .CE(CE),
      .dec(tick), .borrow_in(b_m0), .inc(inc_en[IDX_M1]),
      .borrow_out(b_m1), .q(M1)
   );

   // Top-digit borrow only occurs at 00:00, which tick already excludes.
   logic unused_b_m1;
   assign unused_b_m1 = b_m1;

endmodule

// File: tb/tb_player_time_counter.sv
// Directed bench for player_time_counter with TICK_DIV=4 (reset time 05:00).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_player_time_counter;

   logic       clk = 1'b0;
   logic       clr;
   logic       ce;
   logic       run;
   logic       set_mode;
   logic       set_pulse;
   logic [3:0] inc;
   logic [3:0] m1, m0, s1, s0;
   logic       timeout;

   int errs   = 0;
   int checks = 0;

   always #5 clk = ~clk;

   player_time_counter #(.TICK_DIV(4), .INIT_M1(4'd0), .INIT_M0(4'd5)) dut (
      .CLK(clk), .CLR(clr), .CE(ce), .RUN(run),
      .SET_MODE(set_mode), .SET_PULSE(set_pulse), .INC(inc),
      .M1(m1), .M0(m0), .S1(s1), .S0(s0), .TIMEOUT(timeout)
   );

   task automatic check(input string tag, input logic [15:0] got,
                        input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk_t(input string tag, input logic [15:0] exp_t,
                        input logic exp_to);
      check({tag, ".time"}, {m1, m0, s1, s0}, exp_t);
      check({tag, ".to"}, {15'd0, timeout}, {15'd0, exp_to});
   endtask

   task automatic do_clr();
      clr = 1'b1;
      cyc(2);
      clr = 1'b0;
   endtask

   // One set-mode edit: rising SET_PULSE with the given selects.
   task automatic edit(input logic [3:0] v);
      set_mode  = 1'b1;
      inc       = v;
      set_pulse = 1'b1;
      cyc(1);
      set_pulse = 1'b0;
      inc       = 4'd0;
      cyc(1);
   endtask

   initial begin
      clr = 1'b1; ce = 1'b1; run = 1'b0;
      set_mode = 1'b0; set_pulse = 1'b0; inc = 4'd0;
      @(negedge clk);

      // 1. reset state and idle hold
      do_clr();
      chk_t("rst", 16'h0500, 1'b0);
      cyc(20);
      chk_t("idle", 16'h0500, 1'b0);

      // 2. tick and borrow
      run = 1'b1;
      cyc(3);
      chk_t("pre_tick", 16'h0500, 1'b0);
      cyc(1);
      chk_t("tick1", 16'h0459, 1'b0);
      cyc(4);
      chk_t("tick2", 16'h0458, 1'b0);
      run = 1'b0;
      do_clr();
      edit(4'b1000);
      repeat (5) edit(4'b0100);
      chk_t("set10", 16'h1000, 1'b0);
      set_mode = 1'b0;
      run = 1'b1;
      cyc(4);
      chk_t("borrow_m1", 16'h0959, 1'b0);
      run = 1'b0;

      // 3. timeout saturation
      do_clr();
      repeat (5) edit(4'b0100);
      chk_t("edit_zero", 16'h0000, 1'b0);
      edit(4'b0001);
      chk_t("set0001", 16'h0001, 1'b0);
      set_mode = 1'b0;
      run = 1'b1;
      cyc(4);
      chk_t("flag_fall", 16'h0000, 1'b1);
      cyc(12);
      chk_t("saturate", 16'h0000, 1'b1);
      run = 1'b0;
      edit(4'b0001);
      chk_t("to_clear", 16'h0001, 1'b0);
      set_mode = 1'b0;

      // 4. set-mode edge detection and digit ranges
      do_clr();
      set_mode  = 1'b1;
      inc       = 4'b0001;
      set_pulse = 1'b1;
      cyc(3);
      set_pulse = 1'b0;
      inc       = 4'd0;
      cyc(1);
      chk_t("one_edit", 16'h0501, 1'b0);
      repeat (5) edit(4'b0010);
      chk_t("s1_five", 16'h0551, 1'b0);
      edit(4'b0010);
      chk_t("s1_wrap", 16'h0501, 1'b0);
      edit(4'b1111);
      chk_t("all_inc", 16'h1612, 1'b0);
      set_mode  = 1'b0;
      inc       = 4'b0001;
      set_pulse = 1'b1;
      cyc(1);
      set_mode = 1'b1;
      cyc(1);
      set_pulse = 1'b0;
      inc       = 4'd0;
      cyc(1);
      chk_t("no_edit_off", 16'h1612, 1'b0);
      set_mode = 1'b0;

      // 5. partial-second retention
      do_clr();
      run = 1'b1;
      cyc(2);
      run = 1'b0;
      cyc(5);
      chk_t("partial_hold", 16'h0500, 1'b0);
      run = 1'b1;
      cyc(1);
      chk_t("partial_3", 16'h0500, 1'b0);
      cyc(1);
      chk_t("partial_4", 16'h0459, 1'b0);
      run = 1'b0;

      // 6. priority
      do_clr();
      run      = 1'b1;
      set_mode = 1'b1;
      cyc(16);
      chk_t("set_over_run", 16'h0500, 1'b0);
      run       = 1'b0;
      ce        = 1'b0;
      inc       = 4'b0001;
      set_pulse = 1'b1;
      cyc(1);
      set_pulse = 1'b0;
      cyc(1);
      ce  = 1'b1;
      inc = 4'd0;
      cyc(1);
      chk_t("ce_block", 16'h0500, 1'b0);
      set_mode = 1'b0;
      run = 1'b1;
      ce  = 1'b0;
      cyc(8);
      chk_t("ce_freeze", 16'h0500, 1'b0);
      ce = 1'b1;
      cyc(2);
      clr = 1'b1;
      cyc(1);
      clr = 1'b0;
      chk_t("clr_mid", 16'h0500, 1'b0);
      cyc(3);
      chk_t("post_clr3", 16'h0500, 1'b0);
      cyc(1);
      chk_t("post_clr4", 16'h0459, 1'b0);
      run = 1'b0;

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/player_time_counter.md
Name: player_time_counter

Overview:
- Per-player countdown stage of the chess clock, in mm:ss BCD.
- Sits between the turn/STOP control logic (upstream) and the four 7-segment digit decoders (downstream).
- Top instantiates two copies, one per player; each drives one seg bank.
- Also implements set mode: with STOP active, Set_Impulse plus digit-select switches increment individual digits.

Parameters:
TICK_DIV, 50_000_000, CLK cycles per one-second decrement (TB uses 4)
INIT_M1, 0, reset value of minutes tens digit
INIT_M0, 5, reset value of minutes units digit (reset time = 05:00)

Ports:
CLK  in  1  system clock
CLR  in  1  synchronous active-high reset
CE  in  1  global clock enable; low freezes all state
RUN  in  1  this player's clock is running (turn active, STOP low)
SET_MODE  in  1  edit mode (STOP); suppresses counting
SET_PULSE  in  1  Set_Impulse level; one edit per rising edge
INC  in  4  digit-increment selects [3]=M1 [2]=M0 [1]=S1 [0]=S0
M1  out  4  BCD minutes tens
M0  out  4  BCD minutes units
S1  out  4  BCD seconds tens (0-5)
S0  out  4  BCD seconds units
TIMEOUT  out  1  time reached 00:00 (flag fall)

Behaviour:
- All state updates on rising CLK. CLR is synchronous, active-high, and wins over everything.
- Reset values: M1=INIT_M1, M0=INIT_M0, S1=0, S0=0, TIMEOUT=0, prescaler=0, SET_PULSE edge register=0.
- CE=0: every register holds, including the edge register.
- Count condition: CE & RUN & !SET_MODE & !TIMEOUT.
  - Prescaler increments while the condition holds. At TICK_DIV-1 it wraps to 0 and the time decrements by 1 s in that same edge.
  - Prescaler holds (not cleared) when the condition drops, so partial seconds are preserved across turn changes.
  - Prescaler is forced to 0 while SET_MODE=1.
- Decrement is BCD borrow chain S0 -> S1 -> M0 -> M1:
  - S0 0 -> 9 with borrow
  - S1 0 -> 5 with borrow
  - M0 0 -> 9 with borrow
  - M1 0 never borrows: 00:00 is saturating, never wraps to 99:59.
- Latency: digits show the new value the cycle after the wrapping edge.
- TIMEOUT:
  - Set in the same edge that loads 00:00 via decrement.
  - Sticky; blocks further counting.
  - Cleared only by CLR or by a set-mode edit that yields a nonzero time.
  - 00:00 reached by editing does not set TIMEOUT.
- Set mode: the edit fires when CE & SET_MODE & SET_PULSE & !pulse_q.
  - pulse_q registers SET_PULSE every CE cycle.
  - Each INC bit high increments its digit once, modulo its range: S0 mod 10, S1 mod 6, M0 mod 10, M1 mod 10. No carry between digits.
  - Several INC bits may be high together; all selected digits increment in the same edge.
  - Holding SET_PULSE high gives exactly one edit.
  - SET_PULSE edges while SET_MODE=0 are ignored, but pulse_q still tracks SET_PULSE.
- Simultaneous events:
  - SET_MODE=1 overrides RUN.
  - CLR mid-second discards the prescaler value.
- Digits never leave their legal BCD range. Illegal INIT_* values (>9) are a parameter error checked by assertion.

Decomposition:
- chess_clock_pkg holds:
  - BCD digit width (4)
  - digit limits (9, 5)
  - default TICK_DIV
  - INC bit index constants (IDX_S0..IDX_M1)
- One sub-module, bcd_digit_cell:
  - ports: CLK, CLR, CE, MAX param, reset value param, dec, borrow_in, inc, borrow_out, q
  - implements mod-(MAX+1) decrement-with-borrow and increment-without-carry
  - four instances chained by player_time_counter, which owns the prescaler, edge detect and TIMEOUT.

Test Plan:
1. Reset: CLR=1 for 2 cycles, CE=1 -> M1..S0 = 0,5,0,0; TIMEOUT=0; holds with RUN=0 for 20 cycles.
2. Tick plus borrow: TICK_DIV=4, CE=RUN=1 from 05:00 -> 04:59 after 4 cycles and 04:58 after 8. Start from 10:00 (set M1=1, M0=0 via edits) -> 09:59 after 4 cycles.
3. Timeout saturation: edit time to 00:01, RUN=1 -> 00:00 with TIMEOUT=1 after 4 cycles. A further 12 cycles stay at 00:00, TIMEOUT=1. An edit with INC=0001 -> 00:01 and TIMEOUT=0.
4. Set-mode edge: SET_MODE=1, INC=0001, SET_PULSE high for 3 cycles -> S0 +1 exactly once. Then INC=0010 with S1=5 -> S1=0 and M0 unchanged. INC=1111 in one edge -> all four digits increment.
5. Partial-second retention: TICK_DIV=4, RUN=1 for 2 cycles, RUN=0 for 5, RUN=1 for 2 -> exactly one decrement, occurring on the 4th running cycle.
6. Priority: RUN=1 and SET_MODE=1 together -> no decrement over 16 cycles. CE=0 during a SET_PULSE edge -> no edit. CLR during counting -> 05:00 and prescaler 0, next decrement exactly 4 cycles after CLR release.
